// File: rtl/tug_match_ctrl.sv
// -----------------------------------------------------------------------------
// tug_match_ctrl
//
// Match sequencer for the tug-of-war game. Sits between the synchronized
// player-key flops and the LED rope chain. Turns key presses into one-cycle
// move commands, drops simultaneous presses, detects round wins from the rope
// end LEDs, keeps per-player scores and sequences rounds until one player
// reaches WIN_ROUNDS.
//
// Ports:
//   clk          system clock, all state changes on posedge
//   reset        asynchronous, active-high; clears all state
//   p1_key       player 1 (left) key level, synchronized
//   p2_key       player 2 (right) key level, synchronized
//   left_end     leftmost rope LED lit
//   right_end    rightmost rope LED lit
//   new_match    restarts the match from DONE
//   move         2'b10 = step left, 2'b01 = step right, 2'b00 = none
//   round_reset  re-centres the rope chain (high in START)
//   p1_score     player 1 round wins
//   p2_score     player 2 round wins
//   round_active high while in PLAY
//   match_over   high while in DONE
//   winner       2'b01 = P1, 2'b10 = P2, 2'b00 = none yet
//
// State  | meaning
// -------+----------------------------------------------------------
// START  | one-cycle re-centre pulse, key rises ignored
// PLAY   | round in progress, accepted rises become moves
// HOLD   | post-win pause of HOLD_CYCLES cycles, rises ignored
// DONE   | match finished, winner shown, waits for new_match
// -----------------------------------------------------------------------------
module tug_match_ctrl #(
    parameter int WIN_ROUNDS  = 3,
    parameter int SCORE_W     = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int HOLD_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1_key,
    input  logic               p2_key,
    input  logic               left_end,
    input  logic               right_end,
    input  logic               new_match,
    output logic [1:0]         move,
    output logic               round_reset,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               round_active,
    output logic               match_over,
    output logic [1:0]         winner
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_C     = SCORE_W'(WIN_ROUNDS);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);

    state_t             state_q, state_d;
    logic [1:0]         move_q, move_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [1:0]         winner_q, winner_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               p1_prev_q, p2_prev_q;
    logic               round_reset_q, round_active_q, match_over_q;

    logic p1_rise, p2_rise;
    logic p1_acc, p2_acc;

    assign p1_rise = p1_key & ~p1_prev_q;
    assign p2_rise = p2_key & ~p2_prev_q;

    // Simultaneous rises cancel each other; only a lone rise is a candidate.
    assign p1_acc = p1_rise & ~p2_rise;
    assign p2_acc = p2_rise & ~p1_rise;

    always_comb begin
        state_d    = state_q;
        move_d     = 2'b00;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
        hold_d     = hold_q;

        case (state_q)
            ST_START: begin
                state_d = ST_PLAY;
            end

            ST_PLAY: begin
                if (p1_acc) begin
                    move_d = 2'b10;
                    // Only the pressing player's own end counts as a win.
                    if (left_end) begin
                        p1_score_d = p1_score_q + SCORE_ONE;
                        hold_d     = HOLD_LOAD;
                        state_d    = ST_HOLD;
                    end
                end else if (p2_acc) begin
                    move_d = 2'b01;
                    if (right_end) begin
                        p2_score_d = p2_score_q + SCORE_ONE;
                        hold_d     = HOLD_LOAD;
                        state_d    = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (hold_q == '0) begin
                    if (p1_score_q == WIN_C) begin
                        winner_d = 2'b01;
                        state_d  = ST_DONE;
                    end else if (p2_score_q == WIN_C) begin
                        winner_d = 2'b10;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_START;
                    end
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end

            ST_DONE: begin
                if (new_match) begin
                    p1_score_d = '0;
                    p2_score_d = '0;
                    winner_d   = 2'b00;
                    state_d    = ST_START;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_START;
            move_q         <= 2'b00;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            winner_q       <= 2'b00;
            hold_q         <= '0;
            p1_prev_q      <= 1'b0;
            p2_prev_q      <= 1'b0;
            round_reset_q  <= 1'b1;
            round_active_q <= 1'b0;
            match_over_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            move_q         <= move_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            winner_q       <= winner_d;
            hold_q         <= hold_d;
            // Edge-detect history tracks the keys in every state, so a key
            // held across START or HOLD never produces a late rise.
            p1_prev_q      <= p1_key;
            p2_prev_q      <= p2_key;
            round_reset_q  <= (state_d == ST_START);
            round_active_q <= (state_d == ST_PLAY);
            match_over_q   <= (state_d == ST_DONE);
        end
    end

    assign move         = move_q;
    assign round_reset  = round_reset_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_active = round_active_q;
    assign match_over   = match_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tug_match_ctrl
//
// Self-checking bench for tug_match_ctrl. Each cycle the bench drives inputs,
// pushes the outputs expected after the next clock edge onto a queue, then
// pops and compares them one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_tug_match_ctrl;

    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p1_key = 1'b0;
    logic          p2_key = 1'b0;
    logic          left_end = 1'b0;
    logic          right_end = 1'b0;
    logic          new_match = 1'b0;
    logic [1:0]    move;
    logic          round_reset;
    logic [SW-1:0] p1_score;
    logic [SW-1:0] p2_score;
    logic          round_active;
    logic          match_over;
    logic [1:0]    winner;

    always #5 clk = ~clk;

    tug_match_ctrl #(
        .WIN_ROUNDS (3),
        .SCORE_W    (SW),
        .HOLD_CYCLES(8),
        .HOLD_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p1_key      (p1_key),
        .p2_key      (p2_key),
        .left_end    (left_end),
        .right_end   (right_end),
        .new_match   (new_match),
        .move        (move),
        .round_reset (round_reset),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .round_active(round_active),
        .match_over  (match_over),
        .winner      (winner)
    );

    typedef struct packed {
        logic [1:0]    mv;
        logic          rr;
        logic          ra;
        logic          mo;
        logic [1:0]    win;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
    } exp_t;

    typedef struct {
        logic  p1;
        logic  p2;
        logic  le;
        logic  re;
        logic  nm;
        exp_t  e;
        string name;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic exp_t mk(input logic [1:0] mv, input logic rr, input logic ra,
                                input logic mo, input logic [1:0] win,
                                input logic [SW-1:0] s1, input logic [SW-1:0] s2);
        exp_t e;
        e.mv = mv; e.rr = rr; e.ra = ra; e.mo = mo; e.win = win; e.s1 = s1; e.s2 = s2;
        return e;
    endfunction

    // Expected-output shorthands per state.
    function automatic exp_t e_start(input logic [SW-1:0] s1, input logic [SW-1:0] s2);
        return mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, s1, s2);
    endfunction
    function automatic exp_t e_play(input logic [1:0] mv, input logic [SW-1:0] s1,
                                    input logic [SW-1:0] s2);
        return mk(mv, 1'b0, 1'b1, 1'b0, 2'b00, s1, s2);
    endfunction
    function automatic exp_t e_hold(input logic [1:0] mv, input logic [SW-1:0] s1,
                                    input logic [SW-1:0] s2);
        return mk(mv, 1'b0, 1'b0, 1'b0, 2'b00, s1, s2);
    endfunction
    function automatic exp_t e_done(input logic [1:0] win, input logic [SW-1:0] s1,
                                    input logic [SW-1:0] s2);
        return mk(2'b00, 1'b0, 1'b0, 1'b1, win, s1, s2);
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g.mv = move; g.rr = round_reset; g.ra = round_active; g.mo = match_over;
        g.win = winner; g.s1 = p1_score; g.s2 = p2_score;
        return g;
    endfunction

    task automatic compare(input string name, input exp_t got, input exp_t want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got mv=%b rr=%b ra=%b mo=%b win=%b s1=%0d s2=%0d, expected mv=%b rr=%b ra=%b mo=%b win=%b s1=%0d s2=%0d",
                     name, got.mv, got.rr, got.ra, got.mo, got.win, got.s1, got.s2,
                     want.mv, want.rr, want.ra, want.mo, want.win, want.s1, want.s2);
        end
    endtask

    // Drive one cycle of inputs, expect e after the next edge.
    task automatic step(input logic p1, input logic p2, input logic le, input logic re,
                        input logic nm, input exp_t e, input string name);
        exp_t want;
        p1_key = p1; p2_key = p2; left_end = le; right_end = re; new_match = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        compare(name, observed(), want);
    endtask

    // One round win followed by the full hold; s1/s2 are the scores after the win.
    task automatic win_round(input logic p2w, input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                             input logic final_round);
        logic [1:0] mv;
        logic [1:0] win;
        mv  = p2w ? 2'b01 : 2'b10;
        win = p2w ? 2'b10 : 2'b01;
        step(~p2w, p2w, ~p2w, p2w, 1'b0, e_hold(mv, s1, s2), "win_press");
        for (int i = 1; i <= 7; i++) begin
            // Fresh rises at i=2 (P1) and i=4 (P2) must be ignored in HOLD.
            step((i == 2), (i == 4), 1'b0, 1'b0, 1'b0, e_hold(2'b00, s1, s2), "hold_cycle");
        end
        if (final_round) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_done(win, s1, s2), "enter_done");
        end else begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_start(s1, s2), "hold_to_start");
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_play(2'b00, s1, s2), "start_to_play");
        end
    endtask

    task automatic add(input logic p1, input logic p2, input logic le, input logic re,
                       input logic nm, input logic [1:0] mv, input string name);
        vec_t v;
        v.p1 = p1; v.p2 = p2; v.le = le; v.re = re; v.nm = nm;
        v.e = e_play(mv, '0, '0);
        v.name = name;
        tbl.push_back(v);
    endtask

    localparam exp_t RST = '{mv: 2'b00, rr: 1'b1, ra: 1'b0, mo: 1'b0, win: 2'b00, s1: '0, s2: '0};

    initial begin
        // PLAY-state vectors with scores at zero.
        add(1, 0, 0, 0, 0, 2'b10, "p1_rise");
        add(1, 0, 0, 0, 0, 2'b00, "p1_held_1");
        add(1, 0, 0, 0, 0, 2'b00, "p1_held_2");
        add(0, 0, 0, 0, 0, 2'b00, "p1_release");
        add(0, 1, 0, 0, 0, 2'b01, "p2_rise");
        add(0, 1, 0, 0, 0, 2'b00, "p2_held");
        add(0, 0, 0, 0, 0, 2'b00, "p2_release");
        add(1, 1, 0, 0, 0, 2'b00, "both_rise");
        add(1, 1, 0, 0, 0, 2'b00, "both_held");
        add(0, 1, 0, 0, 0, 2'b00, "p2_still_held");
        add(0, 0, 0, 0, 0, 2'b00, "idle");
        add(1, 0, 0, 1, 0, 2'b10, "p1_far_end_lit");
        add(0, 0, 0, 0, 0, 2'b00, "idle");
        add(0, 1, 1, 0, 0, 2'b01, "p2_far_end_lit");
        add(0, 0, 0, 0, 1, 2'b00, "new_match_in_play");
        add(1, 1, 1, 0, 0, 2'b00, "both_rise_left_end");
        add(0, 0, 0, 0, 0, 2'b00, "idle");

        repeat (2) @(posedge clk);
        #1;
        compare("reset_values", observed(), RST);
        reset = 1'b0;

        step(0, 0, 0, 0, 0, e_play(2'b00, 3'd0, 3'd0), "first_play");
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].p1, tbl[i].p2, tbl[i].le, tbl[i].re, tbl[i].nm, tbl[i].e, tbl[i].name);
        end

        // P1 takes the match.
        win_round(1'b0, 3'd1, 3'd0, 1'b0);
        win_round(1'b0, 3'd2, 3'd0, 1'b0);
        win_round(1'b0, 3'd3, 3'd0, 1'b1);
        step(1, 0, 1, 0, 0, e_done(2'b01, 3'd3, 3'd0), "done_ignores_p1");
        step(0, 1, 0, 1, 0, e_done(2'b01, 3'd3, 3'd0), "done_ignores_p2");
        step(0, 0, 0, 0, 0, e_done(2'b01, 3'd3, 3'd0), "done_idle");
        step(0, 0, 0, 0, 1, e_start(3'd0, 3'd0), "new_match");
        step(0, 0, 0, 0, 0, e_play(2'b00, 3'd0, 3'd0), "rematch_play");

        // P2 to two wins, then reset lands mid-hold with P2 key held.
        win_round(1'b1, 3'd0, 3'd1, 1'b0);
        step(0, 1, 0, 1, 0, e_hold(2'b01, 3'd0, 3'd2), "p2_second_win");
        step(0, 1, 0, 0, 0, e_hold(2'b00, 3'd0, 3'd2), "hold_key_held_1");
        step(0, 1, 0, 0, 0, e_hold(2'b00, 3'd0, 3'd2), "hold_key_held_2");
        #2;
        reset = 1'b1;
        #1;
        compare("async_reset_mid_hold", observed(), RST);
        @(posedge clk);
        #1;
        compare("reset_held", observed(), RST);
        reset = 1'b0;
        step(0, 1, 0, 0, 0, e_play(2'b00, 3'd0, 3'd0), "held_through_reset_1");
        step(0, 1, 0, 0, 0, e_play(2'b00, 3'd0, 3'd0), "held_through_reset_2");
        step(0, 0, 0, 0, 0, e_play(2'b00, 3'd0, 3'd0), "post_reset_release");
        step(0, 1, 0, 0, 0, e_play(2'b01, 3'd0, 3'd0), "post_reset_fresh_rise");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
